// File: rtl/bk_pkg.sv
// Shared definitions for the Brent-Kung pipelined subtractor.
// Optional feature macro: BK_SUB_OVF_EN (signed-overflow output).
package bk_pkg;

  localparam int unsigned PIPE_DEPTH   = 3;
  localparam int unsigned BK_N_DEFAULT = 32;

  // Group generate/propagate vector at the default operand width.
  typedef logic [BK_N_DEFAULT-1:0] gp_vec_t;

  // Number of up-sweep levels in the prefix network.
  function automatic int lvl(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/bk_black_cell.sv
// Brent-Kung black cell: merges a high group (g_hi, p_hi) with the adjacent low group.
module bk_black_cell (
  input  logic g_hi,
  input  logic p_hi,
  input  logic g_lo,
  input  logic p_lo,
  output logic g,
  output logic p
);

  // Group generate/propagate combine.
  always_comb begin
    g = g_hi | (p_hi & g_lo);
    p = p_hi & p_lo;
  end

endmodule

// File: rtl/brent_kung_sub_pipe.sv
// Three-stage valid/ready pipelined subtractor (diff = a - b, borrow = a < b unsigned)
// on a Brent-Kung prefix network. S1: p/g, S2: up-sweep groups, S3: diff/borrow.
// Optional feature macro: BK_SUB_OVF_EN adds the signed-overflow output ovf.
module brent_kung_sub_pipe
  import bk_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] diff,
  output logic         borrow
`ifdef BK_SUB_OVF_EN
  ,
  output logic         ovf
`endif
);

  localparam int LVL = lvl(N);

  logic [PIPE_DEPTH-1:0] v;
  logic adv1, adv2, adv3;

  logic [N-1:0] p_in, g_in;
  logic [N-1:0] s1_p, s1_g;
  logic [N-1:0] up_g [LVL+1];
  logic [N-1:0] up_p [LVL+1];
  logic [N-1:0] s2_p, s2_g, s2_pg;
  logic [N-1:0] dn_g [LVL];
  logic [N-1:0] dn_p [LVL];
  logic [N-1:0] diff_next;
  logic         borrow_next;
  logic         dn_p_unused;

  // Bubble-collapsing handshake: a stage loads when it is empty or its successor moves.
  always_comb begin
    adv3      = out_ready | ~v[2];
    adv2      = adv3 | ~v[1];
    adv1      = adv2 | ~v[0];
    in_ready  = adv1;
    out_valid = v[2];
  end

  // Stage valid bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v <= '0;
    end else begin
      if (adv1) v[0] <= in_valid & in_ready;
      if (adv2) v[1] <= v[0];
      if (adv3) v[2] <= v[1];
    end
  end

  // a + ~b + 1: the carry-in of 1 is folded into bit-0 generate.
  always_comb begin
    p_in    = a ^ ~b;
    g_in    = a & ~b;
    g_in[0] = g_in[0] | p_in[0];
  end

  // S1: bitwise propagate/generate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_p <= '0;
      s1_g <= '0;
    end else if (adv1) begin
      s1_p <= p_in;
      s1_g <= g_in;
    end
  end

  assign up_g[0] = s1_g;
  assign up_p[0] = s1_p;

  // Up-sweep: level s merges bit k with bit k-2^s where k = 2^(s+1)-1 mod 2^(s+1).
  for (genvar s = 0; s < LVL; s++) begin : g_up
    for (genvar k = 0; k < N; k++) begin : g_bit
      if ((k % (1 << (s + 1))) == ((1 << (s + 1)) - 1)) begin : g_cell
        bk_black_cell u_cell (
          .g_hi(up_g[s][k]),
          .p_hi(up_p[s][k]),
          .g_lo(up_g[s][k - (1 << s)]),
          .p_lo(up_p[s][k - (1 << s)]),
          .g   (up_g[s+1][k]),
          .p   (up_p[s+1][k])
        );
      end else begin : g_pass
        assign up_g[s+1][k] = up_g[s][k];
        assign up_p[s+1][k] = up_p[s][k];
      end
    end
  end

  // S2: up-sweep group terms plus the raw propagate needed for the sum XOR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_p  <= '0;
      s2_g  <= '0;
      s2_pg <= '0;
    end else if (adv2) begin
      s2_p  <= s1_p;
      s2_g  <= up_g[LVL];
      s2_pg <= up_p[LVL];
    end
  end

  assign dn_g[0] = s2_g;
  assign dn_p[0] = s2_pg;

  // Down-sweep, s descending: bit j+2^s takes bit j for j = 2^(s+1)-1 mod 2^(s+1).
  // The hi index k = j+2^s is therefore 2^s-1 mod 2^(s+1) with k >= 3*2^s-1.
  for (genvar t = 0; t < LVL - 1; t++) begin : g_dn
    localparam int S = LVL - 2 - t;
    for (genvar k = 0; k < N; k++) begin : g_bit
      if (((k % (1 << (S + 1))) == ((1 << S) - 1)) && (k >= (3 * (1 << S) - 1))) begin : g_cell
        bk_black_cell u_cell (
          .g_hi(dn_g[t][k]),
          .p_hi(dn_p[t][k]),
          .g_lo(dn_g[t][k - (1 << S)]),
          .p_lo(dn_p[t][k - (1 << S)]),
          .g   (dn_g[t+1][k]),
          .p   (dn_p[t+1][k])
        );
      end else begin : g_pass
        assign dn_g[t+1][k] = dn_g[t][k];
        assign dn_p[t+1][k] = dn_p[t][k];
      end
    end
  end

  // Final group propagates are not needed once every carry is resolved.
  assign dn_p_unused = ^dn_p[LVL-1];

  // Sum XOR and borrow from the resolved carries.
  always_comb begin
    diff_next        = '0;
    diff_next[0]     = ~s2_p[0];
    diff_next[N-1:1] = s2_p[N-1:1] ^ dn_g[LVL-1][N-2:0];
    borrow_next      = ~dn_g[LVL-1][N-1];
  end

  // S3: output register, held while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff   <= '0;
      borrow <= 1'b0;
    end else if (adv3) begin
      diff   <= diff_next;
      borrow <= borrow_next;
    end
  end

`ifdef BK_SUB_OVF_EN
  logic s1_sa, s1_sb, s2_sa, s2_sb;

  // Operand sign bits travel alongside the data for the overflow term.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_sa <= 1'b0;
      s1_sb <= 1'b0;
      s2_sa <= 1'b0;
      s2_sb <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      if (adv1) begin
        s1_sa <= a[N-1];
        s1_sb <= b[N-1];
      end
      if (adv2) begin
        s2_sa <= s1_sa;
        s2_sb <= s1_sb;
      end
      if (adv3) ovf <= (s2_sa ^ s2_sb) & (s2_sa ^ diff_next[N-1]);
    end
  end
`endif

endmodule

// File: tb/tb_brent_kung_sub_pipe.sv
// Randomized self-checking bench for brent_kung_sub_pipe (N = 32), checked against
// an in-order queue model with a 3-cycle minimum latency and 3-deep capacity.
// Define BK_SUB_OVF_EN to also exercise the ovf output.
module tb_brent_kung_sub_pipe;

  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] diff;
  logic         borrow;
`ifdef BK_SUB_OVF_EN
  logic         ovf;
`endif

  brent_kung_sub_pipe #(.N(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .diff     (diff),
    .borrow   (borrow)
`ifdef BK_SUB_OVF_EN
    ,
    .ovf      (ovf)
`endif
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    int unsigned  c;
  } op_t;

  op_t q[$];
  int  n_vec = 0;
  int  n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference arithmetic straight from the definitions of difference, borrow and overflow.
  function automatic logic [N-1:0] ref_diff(input logic [N-1:0] x, input logic [N-1:0] y);
    return x - y;
  endfunction

  function automatic logic ref_borrow(input logic [N-1:0] x, input logic [N-1:0] y);
    return x < y;
  endfunction

  function automatic logic ref_ovf(input logic [N-1:0] x, input logic [N-1:0] y);
    longint d;
    d = longint'($signed(x)) - longint'($signed(y));
    return (d > 64'sd2147483647) || (d < -64'sd2147483648);
  endfunction

  // One clock cycle: drive at negedge, check 1 time unit later, update the model.
  task automatic step(input logic iv, input logic [N-1:0] ia, input logic [N-1:0] ib,
                      input logic ordy, output logic fired);
    logic exp_ov;
    op_t  f;
    @(negedge clk);
    in_valid  = iv;
    a         = ia;
    b         = ib;
    out_ready = ordy;
    #1;
    exp_ov = (q.size() > 0) && (cyc >= q[0].c + 3);
    chk("out_valid", {63'd0, out_valid}, {63'd0, exp_ov});
    chk("in_ready", {63'd0, in_ready}, {63'd0, (q.size() < 3) || ordy});
    if (out_valid && (q.size() > 0)) begin
      f = q[0];
      chk("diff", {32'd0, diff}, {32'd0, ref_diff(f.a, f.b)});
      chk("borrow", {63'd0, borrow}, {63'd0, ref_borrow(f.a, f.b)});
`ifdef BK_SUB_OVF_EN
      chk("ovf", {63'd0, ovf}, {63'd0, ref_ovf(f.a, f.b)});
`endif
    end
    fired = iv && in_ready;
    if (out_valid && ordy && (q.size() > 0)) void'(q.pop_front());
    if (fired) q.push_back('{a: ia, b: ib, c: cyc});
  endtask

  task automatic drain(input int n);
    logic f;
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b1, f);
  endtask

  logic [N-1:0] bp_a [5];
  logic [N-1:0] bp_b [5];

  initial begin
    logic         f;
    int           idx;
    logic [N-1:0] ra, rb;
    int unsigned  sel;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    #3;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_diff", {32'd0, diff}, 64'd0);
    chk("rst_borrow", {63'd0, borrow}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed arithmetic cases, each followed by a drain so latency is seen in isolation.
    step(1'b1, 32'd5, 32'd3, 1'b1, f);
    drain(5);
    step(1'b1, 32'd3, 32'd5, 1'b1, f);
    drain(5);
    step(1'b1, 32'd0, 32'd0, 1'b1, f);
    drain(5);
    step(1'b1, 32'h8000_0000, 32'd1, 1'b1, f);
    step(1'b1, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1, f);
    drain(6);

    // Backpressure: 5 offered with the consumer stalled, then released.
    for (int i = 0; i < 5; i++) begin
      bp_a[i] = 32'h1000 * (i + 1) + 32'd7;
      bp_b[i] = 32'd3 * i;
    end
    idx = 0;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, bp_a[idx], bp_b[idx], 1'b0, f);
      if (f) idx++;
    end
    chk("bp_accepted", 64'(idx), 64'd3);
    for (int i = 0; i < 10; i++) begin
      step(idx < 5, (idx < 5) ? bp_a[idx] : '0, (idx < 5) ? bp_b[idx] : '0, 1'b1, f);
      if (f) idx++;
    end
    chk("bp_all_accepted", 64'(idx), 64'd5);
    drain(4);

    // Reset with two operations in flight.
    step(1'b1, 32'd100, 32'd1, 1'b1, f);
    step(1'b1, 32'd200, 32'd2, 1'b1, f);
    #2;
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("midrst_diff", {32'd0, diff}, 64'd0);
    chk("midrst_borrow", {63'd0, borrow}, 64'd0);
    chk("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    drain(6);

    // Random traffic with random valid/ready and biased corner operands.
    for (int i = 0; i < 10000; i++) begin
      sel = $urandom % 8;
      ra  = (sel == 0) ? '0 : (sel == 1) ? '1 : (sel == 2) ? 32'h8000_0000 : N'($urandom);
      sel = $urandom % 8;
      rb  = (sel == 0) ? '0 : (sel == 1) ? '1 : (sel == 2) ? 32'h7FFF_FFFF : N'($urandom);
      step(($urandom % 4) != 0, ra, rb, ($urandom % 3) != 0, f);
    end
    drain(8);
    chk("drain_empty", 64'(q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
